// File: rtl/add_seq32.sv
// add_seq32: multi-cycle add/subtract that time-shares one 8-bit carry-lookahead
// slice across WORDS byte lanes, LSB first, with a registered inter-slice carry.
module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] g, p;
    logic [8:0] c;
    logic       acc, prop;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        acc  = 1'b0;
        prop = 1'b1;
        c[0] = ci;
        // Each carry is a flat sum of products over g/p/ci, not a ripple chain.
        for (int i = 0; i < 8; i++) begin
            acc  = 1'b0;
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = acc | (prop & ci);
        end
        s  = p ^ c[7:0];
        co = c[8];
    end
endmodule

module add_seq32 #(
    parameter int WORDS = 4,
    localparam int N = 8 * WORDS,
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  a_r, b_r, s_r, s_nxt, sum_r;
    logic          carry_r, sa, sb, cout_r, ovf_r;
    logic [IW-1:0] idx;
    logic [IW+2:0] base;
    logic [7:0]    sl_a, sl_b, sl_s;
    logic          sl_co, accept, last;

    assign base   = {idx, 3'b000};
    assign accept = (state == IDLE) && in_valid;
    assign last   = (idx == IW'(WORDS - 1));

    always_comb begin
        sl_a  = a_r[base +: 8];
        sl_b  = b_r[base +: 8];
        s_nxt = s_r;
        s_nxt[base +: 8] = sl_s;
    end

    cla8 u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_r),
        .s  (sl_s),
        .co (sl_co)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= op_sub ? ~b : b;
            s_r     <= '0;
            carry_r <= op_sub;
            idx     <= '0;
            sa      <= a[N-1];
            sb      <= op_sub ? ~b[N-1] : b[N-1];
        end else if (state == RUN) begin
            s_r     <= s_nxt;
            carry_r <= sl_co;
            idx     <= idx + IW'(1);
            // Visible result only changes once the whole word is complete.
            if (last) begin
                sum_r  <= s_nxt;
                cout_r <= sl_co;
                ovf_r  <= (sa == sb) && (sl_s[7] != sa);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
endmodule

// File: tb/tb_add_seq32.sv
// Self-checking bench for add_seq32: directed plan cases plus a randomized
// stream with stalls, scored against a signed/unsigned integer reference.
module tb_add_seq32;
    localparam int WORDS = 4;
    localparam int N = 32;

    logic         clk = 1'b0, rstn = 1'b0;
    logic         in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf;
    logic [N-1:0] sum;
    int           checks = 0, failures = 0;

    always #5 clk = ~clk;

    add_seq32 #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum} from plain 64-bit integer arithmetic
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ur, sr;
        logic   c, o;
        ur = s ? ux - uy : ux + uy;
        sr = s ? sx - sy : sx + sy;
        c  = s ? (ux >= uy) : (ur >= 64'sh1_0000_0000);
        o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {o, c, ur[31:0]};
    endfunction

    task automatic accept_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        int n = 0;
        @(negedge clk);
        a = x; b = y; op_sub = s; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op_sub = ~op_sub;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        chk({tag, "_latency"}, n, WORDS);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] es, input logic ec, input logic eo);
        accept_op(x, y, s);
        wait_done(tag);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_model"}, {ovf, cout, sum}, model(x, y, s));
        release_result();
    endtask

    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [33:0] hold_v;

    initial begin
        int sent = 0, got = 0, cyc = 0;
        logic acc_prev = 1'b0;

        in_valid = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", {ovf, cout, sum}, 34'd0);
        repeat (3) @(negedge clk);
        chk("rst_no_transfer", out_valid, 1'b0);
        in_valid = 1'b0;
        rstn = 1'b1;

        run_op("add_byte", 32'h000000FF, 32'h1, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        run_op("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("sub_neg", 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op("sub_eq", 32'h1234, 32'h1234, 1'b1, 32'h0, 1'b1, 1'b0);

        // backpressure: result held, new operands refused until release
        accept_op(32'h0000000A, 32'h00000005, 1'b0);
        wait_done("bp");
        hold_v = {ovf, cout, sum};
        chk("bp_value", hold_v, model(32'hA, 32'h5, 1'b0));
        @(negedge clk);
        a = 32'h1; b = 32'h1; op_sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", {ovf, cout, sum}, hold_v);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done("bp_next");
        chk("bp_next_sum", sum, 32'd2);
        release_result();

        // reset in the middle of RUN
        accept_op(32'h11111111, 32'h22222222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_outputs", {ovf, cout, sum}, 34'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        begin
            logic seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                seen |= out_valid;
            end
            chk("mid_rst_no_result", seen, 1'b0);
        end
        run_op("post_rst", 32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b0);

        // random stream with stalls on both sides
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_result", {ovf, cout, sum}, e);
                end
                got++;
            end
            if (acc_prev) in_valid = 1'b0;
            acc_prev = 1'b0;
            if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
                a = $urandom;
                b = ($urandom_range(0, 7) == 0) ? a : $urandom;
                op_sub = $urandom_range(0, 1);
                in_valid = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, op_sub));
                sent++;
                acc_prev = 1'b1;
            end
        end
        out_ready = 1'b0;
        chk("rand_count", got, 1000);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
